// File: rtl/imem_loader_if.sv
// Byte-stream handshake and instruction-memory write port of imem_loader.
// The loader is the slave; the stream source and memory model sit on master.
interface imem_loader_if #(
  parameter int AW = 5
) ();
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Packs a little-endian byte stream into 32-bit words and writes them to IMEM from word 0.
// Optional trailing XOR checksum word is enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [AW:0]  i_num_words,
  imem_loader_if.slave bus,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_err
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_FIN   = 3'd4;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_AFTER = S_CHECK;
`else
  localparam logic [2:0] S_AFTER = S_FIN;
`endif
  localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);

  logic [2:0]  r_state;
  logic [AW:0] r_len;
  logic [AW:0] r_wcnt;
  logic [1:0]  r_bcnt;
  logic [31:0] r_asm;

  logic        w_hs;
  logic        w_last_byte;
  logic        w_accept;
  logic [AW:0] w_len_start;
  logic [AW:0] w_wcnt_nxt;
  logic [31:0] w_word;

  function automatic logic [AW:0] clamp_len(input logic [AW:0] n);
    return (n > L_DEPTH) ? L_DEPTH : n;
  endfunction

  assign w_len_start = clamp_len(i_num_words);
  assign w_accept    = (r_state == S_IDLE) && i_start;
  assign w_hs        = bus.in_valid && bus.in_ready;
  assign w_last_byte = w_hs && (r_bcnt == 2'd3);
  assign w_wcnt_nxt  = r_wcnt + 1'b1;
  // New byte enters at the top, so after four shifts byte 0 sits in [7:0].
  assign w_word      = {bus.in_data, r_asm[31:8]};

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign bus.in_ready = (r_state == S_LOAD) || (r_state == S_CHECK);
`else
  assign bus.in_ready = (r_state == S_LOAD);
`endif
  assign bus.mem_we    = (r_state == S_WRITE);
  assign bus.mem_addr  = bus.mem_we ? r_wcnt[AW-1:0] : '0;
  assign bus.mem_wdata = bus.mem_we ? r_asm : '0;
  assign o_busy        = (r_state != S_IDLE);
  assign o_done        = (r_state == S_FIN);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_len   <= '0;
      r_wcnt  <= '0;
      r_bcnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_len   <= w_len_start;
            r_wcnt  <= '0;
            r_bcnt  <= '0;
            r_state <= (w_len_start == '0) ? S_FIN : S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_hs) begin
            r_bcnt <= r_bcnt + 1'b1;
            if (w_last_byte) r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          r_wcnt  <= w_wcnt_nxt;
          r_state <= (w_wcnt_nxt == r_len) ? S_AFTER : S_LOAD;
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (w_hs) begin
            r_bcnt <= r_bcnt + 1'b1;
            if (w_last_byte) r_state <= S_FIN;
          end
        end
`endif
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_hs) r_asm <= w_word;
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] r_csum;
  logic        r_err;

  always_ff @(posedge i_clk) begin
    if (w_accept)                 r_csum <= '0;
    else if (r_state == S_WRITE)  r_csum <= r_csum ^ r_asm;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                                r_err <= 1'b0;
    else if (w_accept)                           r_err <= 1'b0;
    else if ((r_state == S_CHECK) && w_last_byte) r_err <= (w_word != r_csum);
  end

  assign o_err = r_err;
`else
  assign o_err = 1'b0;
`endif
endmodule
